// File: rtl/bin_to_bcd_stream.sv
// bin_to_bcd_stream
// -----------------------------------------------------------------------------
// Sequential binary to packed-BCD converter (shift-add-3 / double dabble).
// Each CONVERT cycle applies the add-3 correction to every digit in parallel and
// shifts one operand bit into the accumulator, so a conversion takes NUM_BITS
// cycles. Ready/valid handshakes on both sides; the result is held stable until
// the downstream consumer takes it. The sign and the number of significant
// digits are reported so a display driver can blank leading zeros.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   bin_in         in   NUM_BITS binary operand
//   bin_in_valid   in   operand valid
//   bin_in_ready   out  block can accept an operand (IDLE, or HOLD with the
//                       result being consumed this cycle)
//   bcd_out        out  4*NUM_DIGITS packed BCD, units digit in [3:0]
//   bcd_out_neg    out  result is negative (always 0 when SIGNED=0)
//   bcd_out_digits out  number of significant digits, 1..NUM_DIGITS
//   bcd_out_valid  out  result valid
//   bcd_out_ready  in   downstream accepts the result
// -----------------------------------------------------------------------------
module bin_to_bcd_stream #(
    parameter int NUM_BITS   = 14,
    parameter int NUM_DIGITS = 5,
    parameter int SIGNED     = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_BITS-1:0]                 bin_in,
    input  logic                                bin_in_valid,
    output logic                                bin_in_ready,
    output logic [4*NUM_DIGITS-1:0]             bcd_out,
    output logic                                bcd_out_neg,
    output logic [$clog2(NUM_DIGITS+1)-1:0]     bcd_out_digits,
    output logic                                bcd_out_valid,
    input  logic                                bcd_out_ready
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int DIG_W = $clog2(NUM_DIGITS + 1);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // Largest magnitude that has to be representable in NUM_DIGITS digits.
    localparam logic [63:0] TEN_POW   = pow10(NUM_DIGITS);
    localparam logic [63:0] MAX_MAG   = (SIGNED != 0) ? (64'd1 << (NUM_BITS - 1))
                                                      : ((64'd1 << NUM_BITS) - 64'd1);

    generate
        if (NUM_BITS < 2 || NUM_BITS > 30) begin : g_bad_width
            $error("bin_to_bcd_stream: NUM_BITS=%0d outside 2..30", NUM_BITS);
        end
        if (TEN_POW <= MAX_MAG) begin : g_bad_digits
            $error("bin_to_bcd_stream: NUM_DIGITS=%0d too small for NUM_BITS=%0d SIGNED=%0d",
                   NUM_DIGITS, NUM_BITS, SIGNED);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t              state_reg;
    logic [NUM_BITS-1:0] mag_reg;
    logic                neg_reg;
    logic [BCD_W-1:0]    acc_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [BCD_W-1:0]    acc_corr;
    logic [BCD_W-1:0]    acc_next;
    logic [DIG_W-1:0]    digits_next;
    logic                in_neg;
    logic [NUM_BITS-1:0] in_mag;
    logic                accept;
    logic                last_step;

    // Unary minus at NUM_BITS width: the most-negative input maps to
    // 2**(NUM_BITS-1), which is correct when read as unsigned.
    assign in_neg = (SIGNED != 0) && bin_in[NUM_BITS-1];
    assign in_mag = in_neg ? -bin_in : bin_in;

    assign bin_in_ready = (state_reg == IDLE) || ((state_reg == HOLD) && bcd_out_ready);
    assign accept       = bin_in_valid && bin_in_ready;
    assign last_step    = (count_reg == CNT_W'(NUM_BITS - 1));

    // Add-3 correction on every digit in parallel, ahead of the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign acc_corr[4*gi +: 4] = (acc_reg[4*gi +: 4] > 4'd4) ? acc_reg[4*gi +: 4] + 4'd3
                                                                      : acc_reg[4*gi +: 4];
        end
    endgenerate

    assign acc_next = {acc_corr[BCD_W-2:0], mag_reg[NUM_BITS-1]};

    // Highest nonzero digit wins; a zero result still reports one digit.
    always_comb begin
        digits_next = DIG_W'(1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc_next[4*i +: 4] != 4'd0) begin
                digits_next = DIG_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mag_reg        <= '0;
            neg_reg        <= 1'b0;
            acc_reg        <= '0;
            count_reg      <= '0;
            bcd_out        <= '0;
            bcd_out_neg    <= 1'b0;
            bcd_out_digits <= '0;
            bcd_out_valid  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Operand load is handled by the accept block below.
                end
                CONVERT: begin
                    acc_reg   <= acc_next;
                    mag_reg   <= mag_reg << 1;
                    count_reg <= count_reg + CNT_W'(1);
                    if (last_step) begin
                        state_reg      <= HOLD;
                        bcd_out        <= acc_next;
                        bcd_out_neg    <= neg_reg;
                        bcd_out_digits <= digits_next;
                        bcd_out_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (bcd_out_ready) begin
                        bcd_out_valid <= 1'b0;
                        if (!bin_in_valid) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Accept from IDLE, or from HOLD on the same edge as the result
            // handshake; placed last so it overrides the state updates above.
            if (accept) begin
                mag_reg   <= in_mag;
                neg_reg   <= in_neg;
                acc_reg   <= '0;
                count_reg <= '0;
                state_reg <= CONVERT;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
module tb_bin_to_bcd_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Unsigned, default-parameter instance
    logic [13:0] u_bin_in = '0;
    logic        u_in_valid = 1'b0;
    logic        u_in_ready;
    logic [19:0] u_bcd;
    logic        u_neg;
    logic [2:0]  u_digits;
    logic        u_out_valid;
    logic        u_out_ready = 1'b1;

    // Signed 8-bit, 3-digit instance
    logic [7:0]  s_bin_in = '0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [11:0] s_bcd;
    logic        s_neg;
    logic [1:0]  s_digits;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;

    bin_to_bcd_stream u_dut (
        .clk(clk), .rst_n(rst_n),
        .bin_in(u_bin_in), .bin_in_valid(u_in_valid), .bin_in_ready(u_in_ready),
        .bcd_out(u_bcd), .bcd_out_neg(u_neg), .bcd_out_digits(u_digits),
        .bcd_out_valid(u_out_valid), .bcd_out_ready(u_out_ready)
    );

    bin_to_bcd_stream #(.NUM_BITS(8), .NUM_DIGITS(3), .SIGNED(1)) s_dut (
        .clk(clk), .rst_n(rst_n),
        .bin_in(s_bin_in), .bin_in_valid(s_in_valid), .bin_in_ready(s_in_ready),
        .bcd_out(s_bcd), .bcd_out_neg(s_neg), .bcd_out_digits(s_digits),
        .bcd_out_valid(s_out_valid), .bcd_out_ready(s_out_ready)
    );

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic [2:0]  digits;
        int          acc_cyc;
    } exp_t;

    exp_t uq[$];
    exp_t sq[$];
    int   urise[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Present an operand, wait (bounded) for acceptance, push its expectation.
    task automatic send_u(input logic [13:0] v, input logic [19:0] bcd, input logic [2:0] dg,
                          input logic ordy);
        exp_t e;
        int n;
        @(negedge clk);
        u_bin_in = v; u_in_valid = 1'b1; u_out_ready = ordy;
        #1;
        n = 0;
        while (!u_in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!u_in_ready) begin
            fail_now("u_accept_timeout");
        end else begin
            e.bcd = bcd; e.neg = 1'b0; e.digits = dg; e.acc_cyc = cyc + 1;
            uq.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic send_s(input logic [7:0] v, input logic [11:0] bcd, input logic neg,
                          input logic [1:0] dg);
        exp_t e;
        int n;
        @(negedge clk);
        s_bin_in = v; s_in_valid = 1'b1;
        #1;
        n = 0;
        while (!s_in_ready && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (!s_in_ready) begin
            fail_now("s_accept_timeout");
        end else begin
            e.bcd = {8'h00, bcd}; e.neg = neg; e.digits = {1'b0, dg}; e.acc_cyc = cyc + 1;
            sq.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((uq.size() != 0 || sq.size() != 0) && n < 400) begin
            @(negedge clk); n++;
        end
        if (uq.size() != 0 || sq.size() != 0) fail_now(name);
        @(negedge clk);
    endtask

    // Unsigned monitor: latency on valid rise, contents on handshake.
    initial begin : mon_u
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (u_out_valid && !prev) begin
                    urise.push_back(cyc);
                    if (uq.size() != 0) chk("u_latency", cyc - uq[0].acc_cyc, 14);
                end
                prev = u_out_valid;
                if (u_out_valid && u_out_ready) begin
                    if (uq.size() == 0) begin
                        fail_now("u_spurious_valid");
                    end else begin
                        e = uq.pop_front();
                        chk("u_bcd", u_bcd, e.bcd);
                        chk("u_neg", u_neg, e.neg);
                        chk("u_digits", u_digits, e.digits);
                        $display("txn u: bcd=%05h neg=%0d digits=%0d (expect %05h %0d %0d)",
                                 u_bcd, u_neg, u_digits, e.bcd, e.neg, e.digits);
                    end
                end
            end
        end
    end

    initial begin : mon_s
        exp_t e;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (s_out_valid && !prev && sq.size() != 0)
                    chk("s_latency", cyc - sq[0].acc_cyc, 8);
                prev = s_out_valid;
                if (s_out_valid && s_out_ready) begin
                    if (sq.size() == 0) begin
                        fail_now("s_spurious_valid");
                    end else begin
                        e = sq.pop_front();
                        chk("s_bcd", {8'h00, s_bcd}, e.bcd);
                        chk("s_neg", s_neg, e.neg);
                        chk("s_digits", s_digits, e.digits);
                        $display("txn s: bcd=%03h neg=%0d digits=%0d (expect %03h %0d %0d)",
                                 s_bcd, s_neg, s_digits, e.bcd[11:0], e.neg, e.digits);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int base;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", u_out_valid, 0);
        chk("rst_bcd", u_bcd, 0);
        chk("rst_digits", u_digits, 0);
        chk("rst_ready", u_in_ready, 1);
        rst_n = 1'b1;

        // Single conversions and boundaries
        send_u(14'd9999, 20'h09999, 3'd4, 1'b1);
        send_u(14'd0, 20'h00000, 3'd1, 1'b1);
        send_u(14'd16383, 20'h16383, 3'd5, 1'b1);
        @(negedge clk); u_in_valid = 1'b0;
        drain("u_drain_basic");

        // Back-pressure: result must hold while operands churn on the input
        send_u(14'd1234, 20'h01234, 3'd4, 1'b0);
        n = 0;
        while (!u_out_valid && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (!u_out_valid) fail_now("u_bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            u_bin_in = 14'(500 + i); u_in_valid = 1'b1;
            #1;
            chk("bp_bcd", u_bcd, 20'h01234);
            chk("bp_in_ready", u_in_ready, 0);
            chk("bp_valid", u_out_valid, 1);
        end
        send_u(14'd777, 20'h00777, 3'd3, 1'b1);
        @(negedge clk); u_in_valid = 1'b0;
        #1;
        chk("bp_valid_drop", u_out_valid, 0);
        drain("u_drain_bp");

        // Back-to-back with valid and ready held high
        base = urise.size();
        send_u(14'd1, 20'h00001, 3'd1, 1'b1);
        send_u(14'd10, 20'h00010, 3'd2, 1'b1);
        send_u(14'd100, 20'h00100, 3'd3, 1'b1);
        @(negedge clk); u_in_valid = 1'b0;
        drain("u_drain_b2b");
        if (urise.size() >= base + 3) begin
            chk("b2b_spacing_1", urise[base+1] - urise[base], 15);
            chk("b2b_spacing_2", urise[base+2] - urise[base+1], 15);
        end else begin
            fail_now("b2b_missing_results");
        end

        // Signed instance
        send_s(8'h80, 12'h128, 1'b1, 2'd3);
        send_s(8'hFF, 12'h001, 1'b1, 2'd1);
        send_s(8'h7F, 12'h127, 1'b0, 2'd3);
        send_s(8'h00, 12'h000, 1'b0, 2'd1);
        @(negedge clk); s_in_valid = 1'b0;
        drain("s_drain");

        // Asynchronous reset mid-conversion
        send_u(14'd5000, 20'h05000, 3'd4, 1'b1);
        u_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_bcd", u_bcd, 0);
        chk("arst_digits", u_digits, 0);
        chk("arst_valid", u_out_valid, 0);
        chk("arst_ready", u_in_ready, 1);
        uq.delete();
        #13;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("post_rst_ready", u_in_ready, 1);
        chk("post_rst_valid", u_out_valid, 0);
        send_u(14'd42, 20'h00042, 3'd2, 1'b1);
        @(negedge clk); u_in_valid = 1'b0;
        drain("u_drain_post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_stream.md
Name: bin_to_bcd_stream

Overview:
Sequential binary-to-packed-BCD converter using shift-add-3 (double dabble). It is generalised in input width, digit count and signedness. Every bit step runs the add-3 correction and the shift in a single cycle, and both input and output use ready/valid handshakes with back-pressure. It sits between numeric datapath sources (counters, ADC results) and the seven-segment display driver. It also reports the sign and the number of significant digits so the driver can blank leading zeros.

Parameters:
NUM_BITS, 14, input word width; legal range 2..30.
NUM_DIGITS, 5, BCD digits produced. An elaboration-time $error fires if the range does not fit:
- SIGNED=0: 10**NUM_DIGITS < 2**NUM_BITS.
- SIGNED=1: 10**NUM_DIGITS <= 2**(NUM_BITS-1).
SIGNED, 0, 1 = bin_in is two's complement; the magnitude is converted and the sign is reported separately.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
bin_in  in  NUM_BITS  binary operand.
bin_in_valid  in  1  operand valid.
bin_in_ready  out  1  block can accept an operand.
bcd_out  out  4*NUM_DIGITS  packed BCD; digit 0 (units) is in [3:0], most-significant digit is in the top nibble.
bcd_out_neg  out  1  result is negative. Always 0 when SIGNED=0.
bcd_out_digits  out  $clog2(NUM_DIGITS+1)  number of significant digits, 1..NUM_DIGITS.
bcd_out_valid  out  1  result valid.
bcd_out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - bcd_out=0, bcd_out_neg=0, bcd_out_digits=0, bcd_out_valid=0.
  - Working registers cleared; bit counter=0.
  - bin_in_ready is decoded from state, so it is 1 in IDLE.
  - Reset mid-conversion or mid-hold aborts the operation: no valid is produced and the operand is lost.
- States: IDLE, CONVERT, HOLD.
- IDLE:
  - bin_in_ready=1.
  - On bin_in_valid at a clock edge (accept), the block latches:
    - mag = |bin_in| when SIGNED=1 and bin_in[MSB]=1, using NUM_BITS-wide two's-complement negation. The most-negative value negates to 2**(NUM_BITS-1) correctly when treated as unsigned.
    - mag = bin_in otherwise.
    - neg = SIGNED & bin_in[MSB].
  - BCD accumulator cleared, count=0, next state CONVERT.
- CONVERT (exactly NUM_BITS cycles):
  - Each cycle, every digit of the accumulator with value >4 has 3 added, all digits in parallel.
  - The corrected accumulator is then shifted left 1, taking mag[MSB] into bit 0; mag shifts left 1; count increments.
  - Add and shift happen in the same cycle; no separate check state.
  - After the NUM_BITS-th step, the next state is HOLD. On that same edge the block registers:
    - bcd_out = accumulator.
    - bcd_out_neg = neg.
    - bcd_out_digits = index of the highest nonzero digit + 1, or 1 if the value is 0.
    - bcd_out_valid = 1.
  - bin_in_ready=0 throughout.
- Latency: bcd_out_valid is first seen high NUM_BITS cycles after the accept edge.
- HOLD:
  - bcd_out_valid=1; all outputs stay stable until a handshake (valid & ready).
  - bin_in_ready = bcd_out_ready (combinational).
  - On handshake with bin_in_valid=1, the new operand is accepted on the same edge: next state CONVERT, bcd_out_valid drops to 0. Sustained throughput is one result per NUM_BITS+1 cycles.
  - On handshake without bin_in_valid: next state IDLE, bcd_out_valid=0.
  - Outputs keep their last values after valid drops; they are don't-care to consumers.
- bin_in is sampled only on the accept edge. Changes to it during CONVERT or HOLD have no effect.
- Negative zero cannot occur, because neg requires the input MSB to be set.
- Digit arithmetic is 4-bit per nibble. After correction no digit exceeds 9. The top digit never overflows, given the elaboration check.

Test Plan:
- Unsigned, defaults: bin_in=9999, bcd_out_ready=1 -> valid exactly 14 cycles after accept; bcd_out=20'h09999, digits=4, neg=0.
- Boundaries, defaults: bin_in=0 -> 20'h00000, digits=1. bin_in=16383 -> 20'h16383, digits=5.
- Back-pressure: accept 1234, hold bcd_out_ready=0 for 20 cycles with bin_in_valid=1 and bin_in changing -> output stable at 20'h01234, bin_in_ready=0. On releasing ready, the pending operand is accepted on the handshake edge and valid drops for one conversion.
- Back-to-back with ready=1 and valid=1 constant: operands 1, 10, 100 -> outputs 1, 10, 100 in order, results spaced 15 cycles apart.
- SIGNED=1, NUM_BITS=8, NUM_DIGITS=3:
  - bin_in=8'h80 -> bcd_out=12'h128, neg=1, digits=3.
  - bin_in=8'hFF -> 12'h001, neg=1, digits=1.
  - bin_in=8'h7F -> 12'h127, neg=0.
- Reset: deassert rst_n at an arbitrary point mid-CONVERT, independent of clk -> outputs clear immediately. After release: IDLE, bin_in_ready=1, no spurious valid; the next conversion of 42 gives 20'h00042.
